// File: rtl/writeback_regfile.sv
// writeback_regfile
//   Consumer end of the MEM/WB pipeline register. It selects the writeback
//   value (load data or ALU result), writes the register file, serves two
//   decode read ports with same-cycle write-through, and keeps a per-register
//   count of in-flight writes. That count drives the decode-stage stall.
//
//   All state updates on the falling clock edge, which is the same edge the
//   pipeline registers use. rst is asynchronous and active-high. Reset clears
//   both the register file and the pending-write counters.
//
//   Optional feature: define ZERO_REG_EN to hardwire register 0 to zero.
//   Register 0 then ignores writes, gets no bypass, is never counted as
//   pending, and never causes a stall. wb_data still shows the mux output.
//
// Ports
//   clk, rst                    clock (negedge active), async active-high reset
//   MemToReg_wb                 1: write back mem_wb, 0: write back alu_wb
//   RegWrite_wb                 writeback enable
//   mem_wb, alu_wb              candidate writeback values
//   RA3_wb                      writeback destination register
//   rs1, rs2 / rd1, rd2         decode read addresses / combinational read data
//   issue_valid                 an instruction leaves decode this cycle
//   issue_regwrite, issue_rd    the issued instruction writes register issue_rd
//   wb_data                     selected writeback value, for forwarding
//   stall                       decode must hold; issue_valid is ignored while high
module writeback_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemToReg_wb,
  input  logic              RegWrite_wb,
  input  logic [DATA_W-1:0] mem_wb,
  input  logic [DATA_W-1:0] alu_wb,
  input  logic [ADDR_W-1:0] RA3_wb,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              issue_valid,
  input  logic              issue_regwrite,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              stall
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [CNT_W-1:0]    cnt  [NUM_REGS];
  logic                we;
  logic                issue_go;
  logic [NUM_REGS-1:0] dec_vec;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] busy_vec;

  // Writeback selection and effective write enable
  always_comb begin
    wb_data = MemToReg_wb ? mem_wb : alu_wb;
`ifdef ZERO_REG_EN
    we = RegWrite_wb && (RA3_wb != '0);
`else
    we = RegWrite_wb;
`endif
  end

  // A register whose only pending writer retires this cycle is not busy:
  // the write-through path already delivers that value to decode.
  always_comb begin
    dec_vec  = '0;
    busy_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      dec_vec[r]  = we && (RA3_wb == ADDR_W'(r));
      busy_vec[r] = (cnt[r] != '0) && !((cnt[r] == CNT_W'(1)) && dec_vec[r]);
    end
  end

  // A full counter also stalls, so the counter can never wrap.
  always_comb begin
    stall = busy_vec[rs1] || busy_vec[rs2] ||
            (issue_regwrite && (cnt[issue_rd] == CNT_MAX));
  end

  always_comb begin
`ifdef ZERO_REG_EN
    issue_go = issue_valid && issue_regwrite && !stall && (issue_rd != '0);
`else
    issue_go = issue_valid && issue_regwrite && !stall;
`endif
    inc_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_vec[r] = issue_go && (issue_rd == ADDR_W'(r));
    end
  end

  // Read ports with same-cycle write-through. With ZERO_REG_EN, we is never
  // set for register 0, and regs[0] stays at its reset value of zero.
  always_comb begin
    rd1 = (we && (RA3_wb == rs1)) ? wb_data : regs[rs1];
    rd2 = (we && (RA3_wb == rs2)) ? wb_data : regs[rs2];
  end

  // Register file state
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (we) begin
      regs[RA3_wb] <= wb_data;
    end
  end

  // Pending-write counters. Simultaneous issue and retire leaves the count
  // unchanged. A retire with nothing pending saturates at zero.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        case ({inc_vec[r], dec_vec[r]})
          2'b10:   cnt[r] <= cnt[r] + CNT_W'(1);
          2'b01:   if (cnt[r] != '0) cnt[r] <= cnt[r] - CNT_W'(1);
          default: cnt[r] <= cnt[r];
        endcase
      end
    end
  end

endmodule
